io_spi_shift_cell: RTL and testbench
====================================

# io_spi_shift_cell

SPI-mode-0 shift engine that consumes `divided_clk` from the IO clock generation cell and uses it as the serial bit clock for a 16-bit full-duplex transfer. It sits on the same IO config bus as the clock cell, with the same ACK/REQ, LoadEn and RegDest semantics. A config write starts a transfer; a config load returns the last received word. All logic runs in `sys_clk`. `divided_clk` is treated as an asynchronous data input: it is synchronized and edge-detected, never used as a clock.

## Interface
- DATABITWIDTH, 16, width of `ResponseDataOut`; must be ≥16.
- SYNCSTAGES, 2, synchronizer depth for `divided_clk` and `spi_miso`; must be ≥2.

Ports:
- sys_clk  in  1  sole clock.
- sync_rst  in  1  reset; synchronous, active-high.
- clk_en  in  1  global enable; when low, every register holds.
- divided_clk  in  1  bit clock from the clock generation cell; asynchronous to `sys_clk`.
- ConfigACK  in  1  bus valid; a transaction occurs when `ConfigACK && ConfigREQ`.
- ConfigREQ  out  1  bus ready.
- LoadEn  in  1  1 = load (read RX word), 0 = write (start TX).
- ConfigWordIn  in  16  TX data, sent MSB first.
- ConfigRegDestIn  in  4  destination register tag.
- ResponseACK  out  1  response valid.
- ResponseREQ  in  1  response sink ready.
- ResponseRegDestOut  out  4  combinational passthrough of `ConfigRegDestIn`.
- ResponseDataOut  out  DATABITWIDTH  `{'0, RxData}`.
- spi_sclk  out  1  serial clock.
- spi_mosi  out  1  serial data out.
- spi_cs_n  out  1  chip select, active-low.
- spi_miso  in  1  serial data in; asynchronous.

## Operation
- Synchronizer:
  - `divided_clk` passes through SYNCSTAGES flops to give `ClkSync`, plus one more flop to give `ClkPrev`.
  - RiseTick = `ClkSync & ~ClkPrev`. FallTick = `~ClkSync & ClkPrev`.
  - `spi_miso` passes through an identical SYNCSTAGES chain so it stays aligned with `ClkSync`.
  - Ticks are generated only when `clk_en` = 1.
- State machine: IDLE, ARM, SHIFT, DONE.
  - Busy = ARM | SHIFT | DONE.
- Bus signals:
  - `ConfigREQ = LoadEn ? (ResponseREQ & ~Busy) : (~Busy & clk_en)`.
  - `ResponseACK = ConfigACK & LoadEn & ConfigREQ`.
- IDLE:
  - On a write: TxShift ← ConfigWordIn, BitCount ← 0, `spi_cs_n` ← 0, go to ARM.
  - A load only asserts `ResponseACK`. RxData is not cleared by a load.
- ARM:
  - `spi_sclk` = 0, `spi_mosi` = TxShift[15].
  - On FallTick, go to SHIFT. This guarantees a full low half-period before the first rising edge.
- SHIFT:
  - `spi_sclk` = `ClkSync`.
  - On RiseTick: RxShift ← {RxShift[14:0], MisoSync}, BitCount++.
  - On FallTick: if BitCount == 16, go to DONE; otherwise TxShift ← TxShift << 1.
- DONE (one cycle): RxData ← RxShift, `spi_cs_n` ← 1, go to IDLE.
- BitCount is 5 bits and counts 0..16; it never wraps.
- `spi_sclk`, `spi_mosi` and `spi_cs_n` are registered outputs, or decoded only from registered state.
- Write while Busy: refused (`ConfigREQ` = 0). Load while Busy: refused.
- `LoadEn` chooses exactly one action per handshake.
- Mid-transfer `sync_rst`: the transfer aborts, no response is produced, RxData = 0.
- `clk_en` low mid-transfer: state, shift registers and synchronizers freeze. Edges of `divided_clk` during the freeze are lost. Resuming sees at most one tick.
- Constraint on the source: each `divided_clk` half-period must be ≥ SYNCSTAGES+2 `sys_clk` cycles.

## Timing
- Reset values:
  - State IDLE, `spi_cs_n` = 1, `spi_sclk` = 0, `spi_mosi` = 0.
  - TxShift, RxShift, RxData, BitCount and all synchronizer flops = 0.
  - `ResponseACK` = 0; `ConfigREQ` as decoded in IDLE.
- Write accept edge → `spi_cs_n` = 0 and `spi_mosi` = bit 15 on the next cycle.
- Each `divided_clk` edge → matching `spi_sclk` edge SYNCSTAGES+1 cycles later.
- Each `spi_mosi` change occurs in the same cycle as the `spi_sclk` falling edge.
- Last FallTick → DONE on the next cycle. `spi_cs_n` = 1 and RxData valid one cycle after that. `ConfigREQ` re-asserts in the same cycle.
- Load response is combinational in the handshake cycle.

## Test plan
- Reset: hold `sync_rst` 3 cycles → `spi_cs_n` = 1, `spi_sclk` = 0, `spi_mosi` = 0; a load with tag 4'h3 returns data 0x0000 with tag 4'h3.
- Loopback (`spi_miso` = `spi_mosi`), `divided_clk` period 12 `sys_clk`, write 0xA5C3 → exactly 16 `spi_sclk` rises; `spi_mosi` carries 1010_0101_1100_0011 MSB first; `spi_cs_n` rises after the 16th fall; a load with tag 4'h7 returns 0xA5C3 with tag 4'h7.
- `spi_miso` tied 1, write 0x0000 → load returns 0xFFFF. `spi_miso` tied 0, write 0xFFFF → load returns 0x0000.
- During a transfer, `ConfigACK` = 1 with `LoadEn` both 0 and 1, `ResponseREQ` = 1 → `ConfigREQ` = 0 throughout; TxShift is unchanged; `ResponseACK` = 0.
- `sync_rst` pulsed after the 7th rise → next cycle `spi_cs_n` = 1, `spi_sclk` = 0, state IDLE; a following load returns 0x0000.
- `clk_en` = 0 in IDLE with `ConfigACK` = 1, `LoadEn` = 0 → write `ConfigREQ` = 0; no transfer starts, and `spi_cs_n` stays 1 for 50 cycles.

Source files
------------

// File: rtl/io_spi_shift_cell.sv
// io_spi_shift_cell: SPI mode-0 16-bit full-duplex shift engine whose bit clock is a
// synchronized, edge-detected copy of divided_clk; everything runs on sys_clk.
module io_spi_shift_cell #(
  parameter int DATABITWIDTH = 16,
  parameter int SYNCSTAGES = 2
) (
  input  logic                    sys_clk,
  input  logic                    sync_rst,
  input  logic                    clk_en,
  input  logic                    divided_clk,
  input  logic                    ConfigACK,
  output logic                    ConfigREQ,
  input  logic                    LoadEn,
  input  logic [15:0]             ConfigWordIn,
  input  logic [3:0]              ConfigRegDestIn,
  output logic                    ResponseACK,
  input  logic                    ResponseREQ,
  output logic [3:0]              ResponseRegDestOut,
  output logic [DATABITWIDTH-1:0] ResponseDataOut,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  output logic                    spi_cs_n,
  input  logic                    spi_miso
);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [SYNCSTAGES-1:0] clkChain, misoChain;
  logic clkPrev, clkSync, misoSync, riseTick, fallTick, busy, writeFire;
  logic [15:0] txShift, rxShift, rxData;
  logic [4:0] bitCount;
  logic sclkReg, csNReg;
  assign clkSync = clkChain[SYNCSTAGES-1];
  assign misoSync = misoChain[SYNCSTAGES-1];
  assign riseTick = clk_en & clkSync & ~clkPrev;
  assign fallTick = clk_en & ~clkSync & clkPrev;
  assign busy = state != IDLE;
  assign ConfigREQ = LoadEn ? (ResponseREQ & ~busy) : (~busy & clk_en);
  assign ResponseACK = ConfigACK & LoadEn & ConfigREQ;
  assign writeFire = ConfigACK & ~LoadEn & ConfigREQ;
  assign ResponseRegDestOut = ConfigRegDestIn;
  assign ResponseDataOut = DATABITWIDTH'(rxData);
  assign spi_sclk = sclkReg;
  assign spi_mosi = txShift[15];
  assign spi_cs_n = csNReg;
  // sclk is re-registered from clkSync so its edges line up with the tx shift on a fall
  always_ff @(posedge sys_clk)
    if (sync_rst) begin
      clkChain <= '0;
      misoChain <= '0;
      clkPrev <= 1'b0;
      state <= IDLE;
      txShift <= '0;
      rxShift <= '0;
      rxData <= '0;
      bitCount <= '0;
      sclkReg <= 1'b0;
      csNReg <= 1'b1;
    end else if (clk_en) begin
      clkChain <= {clkChain[SYNCSTAGES-2:0], divided_clk};
      misoChain <= {misoChain[SYNCSTAGES-2:0], spi_miso};
      clkPrev <= clkSync;
      sclkReg <= (state == SHIFT) & clkSync;
      if (writeFire) begin
        txShift <= ConfigWordIn;
        bitCount <= '0;
        csNReg <= 1'b0;
        state <= ARM;
      end
      if (state == ARM && fallTick) state <= SHIFT;
      if (state == SHIFT && riseTick) begin
        rxShift <= {rxShift[14:0], misoSync};
        if (bitCount != 5'd16) bitCount <= bitCount + 5'd1;
      end
      if (state == SHIFT && fallTick) begin
        if (bitCount == 5'd16) state <= DONE;
        else txShift <= {txShift[14:0], 1'b0};
      end
      if (state == DONE) begin
        rxData <= rxShift;
        csNReg <= 1'b1;
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_io_spi_shift_cell.sv
// tb_io_spi_shift_cell: randomized bench with an SPI slave/monitor model for io_spi_shift_cell.
module tb_io_spi_shift_cell;
  logic sys_clk = 1'b0, sync_rst = 1'b1, clk_en = 1'b1, divided_clk = 1'b0;
  logic ConfigACK = 1'b0, LoadEn = 1'b0, ResponseREQ = 1'b0;
  logic [15:0] ConfigWordIn = '0;
  logic [3:0] ConfigRegDestIn = '0;
  logic ConfigREQ, ResponseACK, spi_sclk, spi_mosi, spi_cs_n, spi_miso;
  logic [3:0] ResponseRegDestOut;
  logic [15:0] ResponseDataOut;
  logic loopMode = 1'b1, slaveBit = 1'b0, sclkPrev = 1'b0, csPrev = 1'b1;
  logic [15:0] slaveWord = '0, capMosi = '0;
  int riseCount = 0, slaveIdx = 0, divCnt = 0, errors = 0, checks = 0;

  io_spi_shift_cell dut (
    .sys_clk(sys_clk), .sync_rst(sync_rst), .clk_en(clk_en), .divided_clk(divided_clk),
    .ConfigACK(ConfigACK), .ConfigREQ(ConfigREQ), .LoadEn(LoadEn), .ConfigWordIn(ConfigWordIn),
    .ConfigRegDestIn(ConfigRegDestIn), .ResponseACK(ResponseACK), .ResponseREQ(ResponseREQ),
    .ResponseRegDestOut(ResponseRegDestOut), .ResponseDataOut(ResponseDataOut),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
  );

  assign spi_miso = loopMode ? spi_mosi : slaveBit;
  always #5 sys_clk = ~sys_clk;

  // divided_clk: period 12 sys_clk cycles, free running
  always @(posedge sys_clk)
    if (divCnt == 5) begin
      divCnt <= 0;
      divided_clk <= ~divided_clk;
    end else divCnt <= divCnt + 1;

  // SPI slave + bus monitor: captures mosi on sclk rises, shifts slaveWord out MSB first on falls
  always @(negedge sys_clk) begin
    if (csPrev && !spi_cs_n) begin
      riseCount <= 0;
      capMosi <= '0;
      slaveIdx <= 0;
      slaveBit <= slaveWord[15];
    end
    if (!spi_cs_n && !sclkPrev && spi_sclk) begin
      capMosi <= {capMosi[14:0], spi_mosi};
      riseCount <= riseCount + 1;
    end
    if (!spi_cs_n && sclkPrev && !spi_sclk) begin
      slaveIdx <= slaveIdx + 1;
      if (slaveIdx < 15) slaveBit <= slaveWord[14 - slaveIdx];
    end
    sclkPrev <= spi_sclk;
    csPrev <= spi_cs_n;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic doWrite(input logic [15:0] w, output logic req, output logic csN, output logic mosi);
    ConfigACK = 1'b1;
    LoadEn = 1'b0;
    ConfigWordIn = w;
    #1 req = ConfigREQ;
    tick();
    ConfigACK = 1'b0;
    csN = spi_cs_n;
    mosi = spi_mosi;
  endtask

  task automatic doLoad(input logic [3:0] tag, output logic ack, output logic [15:0] data, output logic [3:0] rtag);
    ConfigACK = 1'b1;
    LoadEn = 1'b1;
    ResponseREQ = 1'b1;
    ConfigRegDestIn = tag;
    #1;
    ack = ResponseACK;
    data = ResponseDataOut;
    rtag = ResponseRegDestOut;
    tick();
    ConfigACK = 1'b0;
    LoadEn = 1'b0;
  endtask

  task automatic waitDone(output logic ok);
    int n = 0;
    while (spi_cs_n !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    ok = spi_cs_n === 1'b1;
  endtask

  task automatic test_reset();
    logic ack;
    logic [15:0] d;
    logic [3:0] t;
    sync_rst = 1'b1;
    tick(3);
    checks++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: cs_n=%b sclk=%b mosi=%b want 1 0 0", spi_cs_n, spi_sclk, spi_mosi);
    end
    sync_rst = 1'b0;
    tick();
    doLoad(4'h3, ack, d, t);
    checks++;
    if (ack !== 1'b1 || d !== 16'h0000 || t !== 4'h3) begin
      errors++;
      $display("FAIL reset_load: ack=%b data=%h tag=%h want 1 0000 3", ack, d, t);
    end
  endtask

  task automatic test_transfer(input logic [15:0] tx, input logic [15:0] slv, input logic loop, input logic [3:0] tag);
    logic req, csN, mosi, ok, ack;
    logic [15:0] d, expRx;
    logic [3:0] t;
    loopMode = loop;
    slaveWord = slv;
    expRx = loop ? tx : slv;
    doWrite(tx, req, csN, mosi);
    checks++;
    if (req !== 1'b1 || csN !== 1'b0 || mosi !== tx[15]) begin
      errors++;
      $display("FAIL xfer_start(%h): req=%b cs_n=%b mosi=%b want 1 0 %b", tx, req, csN, mosi, tx[15]);
    end
    waitDone(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL xfer_timeout(%h): cs_n=%b want 1", tx, spi_cs_n);
    end
    checks++;
    if (riseCount != 16 || capMosi !== tx) begin
      errors++;
      $display("FAIL xfer_mosi(%h): rises=%0d mosi_word=%h want 16 %h", tx, riseCount, capMosi, tx);
    end
    doLoad(tag, ack, d, t);
    checks++;
    if (ack !== 1'b1 || d !== expRx || t !== tag) begin
      errors++;
      $display("FAIL xfer_load(%h): ack=%b data=%h tag=%h want 1 %h %h", tx, ack, d, t, expRx, tag);
    end
  endtask

  task automatic test_busy();
    logic req, csN, mosi, ok, ack;
    logic [15:0] d, slv;
    logic [3:0] t;
    int bad = 0;
    loopMode = 1'b0;
    slv = 16'($urandom);
    slaveWord = slv;
    doWrite(16'h1234, req, csN, mosi);
    for (int i = 0; i < 40; i++) begin
      ConfigACK = 1'b1;
      LoadEn = i[0];
      ResponseREQ = 1'b1;
      ConfigWordIn = 16'($urandom);
      #1;
      checks++;
      if (ConfigREQ !== 1'b0 || ResponseACK !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL busy_refuse: req=%b resp_ack=%b want 0 0", ConfigREQ, ResponseACK);
      end
      tick();
    end
    ConfigACK = 1'b0;
    LoadEn = 1'b0;
    waitDone(ok);
    checks++;
    if (!ok || riseCount != 16 || capMosi !== 16'h1234) begin
      errors++;
      $display("FAIL busy_tx_kept: done=%b rises=%0d mosi_word=%h want 1 16 1234", ok, riseCount, capMosi);
    end
    doLoad(4'hA, ack, d, t);
    checks++;
    if (ack !== 1'b1 || d !== slv) begin
      errors++;
      $display("FAIL busy_load: ack=%b data=%h want 1 %h", ack, d, slv);
    end
  endtask

  task automatic test_reset_mid();
    logic req, csN, mosi, ack;
    logic [15:0] d;
    logic [3:0] t;
    int n = 0;
    loopMode = 1'b1;
    doWrite(16'h5A5A, req, csN, mosi);
    while (riseCount < 7 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (riseCount < 7) begin
      errors++;
      $display("FAIL midrst_wait: rises=%0d want 7", riseCount);
    end
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    #1;
    checks++;
    if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || ConfigREQ !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: cs_n=%b sclk=%b write_req=%b want 1 0 1", spi_cs_n, spi_sclk, ConfigREQ);
    end
    tick();
    doLoad(4'h5, ack, d, t);
    checks++;
    if (ack !== 1'b1 || d !== 16'h0000 || t !== 4'h5) begin
      errors++;
      $display("FAIL midrst_load: ack=%b data=%h tag=%h want 1 0000 5", ack, d, t);
    end
  endtask

  task automatic test_clk_en();
    int bad = 0;
    clk_en = 1'b0;
    ConfigACK = 1'b1;
    LoadEn = 1'b0;
    ConfigWordIn = 16'hFFFF;
    for (int i = 0; i < 50; i++) begin
      #1;
      checks++;
      if (ConfigREQ !== 1'b0 || spi_cs_n !== 1'b1) begin
        errors++;
        bad++;
        if (bad < 4) $display("FAIL clken_hold: req=%b cs_n=%b want 0 1", ConfigREQ, spi_cs_n);
      end
      tick();
    end
    ConfigACK = 1'b0;
    clk_en = 1'b1;
    tick(3);
    checks++;
    if (spi_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL clken_nostart: cs_n=%b want 1", spi_cs_n);
    end
  endtask

  initial begin
    test_reset();
    test_transfer(16'hA5C3, 16'h0000, 1'b1, 4'h7);
    test_transfer(16'h0000, 16'hFFFF, 1'b0, 4'h1);
    test_transfer(16'hFFFF, 16'h0000, 1'b0, 4'h2);
    for (int i = 0; i < 4; i++)
      test_transfer(16'($urandom), 16'($urandom), 1'b0, 4'($urandom_range(15)));
    test_busy();
    test_reset_mid();
    test_clk_en();
    test_transfer(16'h3C96, 16'h0000, 1'b1, 4'hE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
